// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a small write FIFO
// Frame shape (data bits, parity, stop bits) is fixed by parameters.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 434,
  parameter int DATA_BITS   = 7,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  input  logic [DATA_BITS-1:0]        wr_data,
  output logic                        wr_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_next;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop;
  logic [DATA_BITS-1:0] shift, data_reg;
  logic [CW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 bit_done, parity_bit, tx_next, busy_next;

  // Ready depends only on the registered count, so a full FIFO refuses a write
  // even on an edge where the FSM pops.
  assign wr_ready   = (fifo_count != (AW+1)'(FIFO_DEPTH));
  assign push       = wr_valid & wr_ready;
  assign bit_done   = (baud_cnt == CW'(CLK_PER_BIT - 1));
  assign parity_bit = (PARITY_MODE == 2) ? ~^data_reg : ^data_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= wr_valid & ~wr_ready;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    tx_next    = tx;
    busy_next  = busy;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop        = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          tx_next    = shift[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == IW'(DATA_BITS - 1)) begin
            if (PARITY_MODE != 0) begin
              state_next = PARITY;
              tx_next    = parity_bit;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            tx_next = shift[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        // Back-to-back frames: pop straight into the next start bit.
        if (bit_done && stop_idx == 1'(STOP_BITS - 1)) begin
          if (fifo_count != '0) begin
            pop        = 1'b1;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      shift    <= '0;
      data_reg <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      state <= state_next;
      tx    <= tx_next;
      busy  <= busy_next;
      if (state == IDLE || bit_done) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + 1'b1;
      if (pop) begin
        shift    <= mem[rd_ptr];
        data_reg <= mem[rd_ptr];
        bit_idx  <= '0;
      end else if (state == DATA && bit_done) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
      if (state != STOP)  stop_idx <= 1'b0;
      else if (bit_done)  stop_idx <= stop_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo, three frame formats
// DUT a: 7 bits even parity 1 stop; b: 8 bits odd parity 2 stop; c: 8 bits no parity 1 stop.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int rst_count = 0;
  always @(posedge rst) rst_count = rst_count + 1;

  logic       wv_a, wv_b, wv_c;
  logic [6:0] wd_a;
  logic [7:0] wd_b, wd_c;
  logic       rdy_a, rdy_b, rdy_c, tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;

  uart_tx_fifo #(.CLK_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .wr_valid(wv_a), .wr_data(wd_a), .wr_ready(rdy_a),
    .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a), .overflow(ovf_a));
  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .wr_valid(wv_b), .wr_data(wd_b), .wr_ready(rdy_b),
    .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b), .overflow(ovf_b));
  uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0)) dut_c (
    .clk(clk), .rst(rst), .wr_valid(wv_c), .wr_data(wd_c), .wr_ready(rdy_c),
    .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c), .overflow(ovf_c));

  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];
  logic [15:0] sb_c[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Line levels in transmit order, bit 0 = start bit; unused upper bits stay 1.
  function automatic logic [15:0] frame(input logic [7:0] d, input int db, input int pm);
    logic [15:0] f;
    logic p;
    f = '1;
    f[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[1+i] = d[i];
      p ^= d[i];
    end
    if (pm != 0) f[1+db] = (pm == 2) ? ~p : p;
    return f;
  endfunction

  function automatic logic tx_of(input int k);
    return (k == 0) ? tx_a : (k == 1) ? tx_b : tx_c;
  endfunction

  function automatic logic busy_of(input int k);
    return (k == 0) ? busy_a : (k == 1) ? busy_b : busy_c;
  endfunction

  // Drive one write for one edge; leaves wr_valid high so calls chain back-to-back.
  task automatic wr(input int k, input logic [7:0] d, input logic exp_ready);
    case (k)
      0: begin
        check("wr_ready_a", 32'(rdy_a), 32'(exp_ready));
        wv_a = 1'b1; wd_a = d[6:0];
        if (exp_ready) sb_a.push_back(frame(d, 7, 1));
      end
      1: begin
        check("wr_ready_b", 32'(rdy_b), 32'(exp_ready));
        wv_b = 1'b1; wd_b = d;
        if (exp_ready) sb_b.push_back(frame(d, 8, 2));
      end
      default: begin
        check("wr_ready_c", 32'(rdy_c), 32'(exp_ready));
        wv_c = 1'b1; wd_c = d;
        if (exp_ready) sb_c.push_back(frame(d, 8, 0));
      end
    endcase
    @(negedge clk);
  endtask

  task automatic wait_idle(input int k, input int exp_end, input string tag);
    int endc;
    endc = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy_of(k) == 1'b0) begin
        endc = cyc;
        break;
      end
    end
    check(tag, endc, exp_end);
  endtask

  // Samples each bit mid-period and compares the whole frame with the scoreboard.
  task automatic monitor(input int k, input int len);
    logic [15:0] got, e;
    int rc;
    forever begin
      @(negedge clk);
      if (!rst && tx_of(k) === 1'b0) begin
        rc = rst_count;
        got = '1;
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
          got[i] = tx_of(k);
          if (i < len - 1) repeat (4) @(negedge clk);
        end
        if (rc == rst_count && !rst) begin
          case (k)
            0: begin
              check("sb_a_has_entry", 32'(sb_a.size() != 0), 32'd1);
              if (sb_a.size() != 0) begin e = sb_a.pop_front(); check("frame_a", 32'(got), 32'(e)); end
            end
            1: begin
              check("sb_b_has_entry", 32'(sb_b.size() != 0), 32'd1);
              if (sb_b.size() != 0) begin e = sb_b.pop_front(); check("frame_b", 32'(got), 32'(e)); end
            end
            default: begin
              check("sb_c_has_entry", 32'(sb_c.size() != 0), 32'd1);
              if (sb_c.size() != 0) begin e = sb_c.pop_front(); check("frame_c", 32'(got), 32'(e)); end
            end
          endcase
        end
      end
    end
  endtask

  initial monitor(0, 10);
  initial monitor(1, 12);
  initial monitor(2, 10);

  initial begin
    int n, m;
    logic ok;
    wv_a = 1'b0; wv_b = 1'b0; wv_c = 1'b0;
    wd_a = '0; wd_b = '0; wd_c = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_ready", 32'(rdy_a), 32'd1);
    check("rst_count", 32'(cnt_a), 32'd0);
    check("rst_overflow", 32'(ovf_a), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single 7'h41 frame: start one edge after acceptance, busy for 40 cycles
    wr(0, 8'h41, 1'b1); wv_a = 1'b0; n = cyc;
    check("t1_tx_before_start", 32'(tx_a), 32'd1);
    @(negedge clk);
    check("t1_tx_start", 32'(tx_a), 32'd0);
    check("t1_busy_start", 32'(busy_a), 32'd1);
    wait_idle(0, n + 41, "t1_busy_end");

    // Five writes fill the FIFO, sixth overflows; frames run back-to-back
    repeat (2) @(negedge clk);
    wr(0, 8'h11, 1'b1); n = cyc;
    wr(0, 8'h22, 1'b1);
    wr(0, 8'h33, 1'b1);
    wr(0, 8'h44, 1'b1);
    wr(0, 8'h55, 1'b1);
    wr(0, 8'h66, 1'b0); wv_a = 1'b0;
    check("t2_overflow_pulse", 32'(ovf_a), 32'd1);
    check("t2_count_full", 32'(cnt_a), 32'd4);
    @(negedge clk);
    check("t2_overflow_clear", 32'(ovf_a), 32'd0);
    check("t2_ready_full", 32'(rdy_a), 32'd0);
    wait_idle(0, n + 201, "t2_contiguous_end");

    // Write on the pop edge with one entry queued
    repeat (2) @(negedge clk);
    wr(0, 8'h0A, 1'b1); wv_a = 1'b0; n = cyc;
    @(negedge clk);
    wr(0, 8'h0B, 1'b1); wv_a = 1'b0;
    check("t5_count_one", 32'(cnt_a), 32'd1);
    while (cyc < n + 40) @(negedge clk);
    wr(0, 8'h0C, 1'b1); wv_a = 1'b0;
    check("t5_count_stays", 32'(cnt_a), 32'd1);
    check("t5_no_overflow", 32'(ovf_a), 32'd0);
    check("t5_next_start", 32'(tx_a), 32'd0);
    wait_idle(0, n + 121, "t5_end");

    // Other frame formats: 8N1 zeros and 8O2 ones
    repeat (2) @(negedge clk);
    wr(2, 8'h00, 1'b1); wv_c = 1'b0; n = cyc;
    wr(1, 8'hFF, 1'b1); wv_b = 1'b0; m = cyc;
    wait_idle(2, n + 41, "t4_c_frame_len");
    wait_idle(1, m + 49, "t3_b_frame_len");

    // Reset mid-frame with two queued
    repeat (2) @(negedge clk);
    wr(0, 8'h15, 1'b1); n = cyc;
    wr(0, 8'h2A, 1'b1);
    wr(0, 8'h3F, 1'b1); wv_a = 1'b0;
    check("t6_count_two", 32'(cnt_a), 32'd2);
    while (cyc < n + 8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_tx", 32'(tx_a), 32'd1);
    check("t6_rst_busy", 32'(busy_a), 32'd0);
    check("t6_rst_count", 32'(cnt_a), 32'd0);
    check("t6_rst_ready", 32'(rdy_a), 32'd1);
    sb_a.delete();
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) ok = 1'b0;
    end
    check("t6_quiet_after_reset", 32'(ok), 32'd1);

    check("sb_a_drained", sb_a.size(), 32'd0);
    check("sb_b_drained", sb_b.size(), 32'd0);
    check("sb_c_drained", sb_c.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
